// File: rtl/dpram_arbiter_if.sv
// dpram_arbiter_if: requester-side bus of the dual-port RAM arbiter (requests, grants, read responses).
interface dpram_arbiter_if #(parameter int N = 4, parameter int AW = 6, parameter int DW = 8);
  logic [N-1:0]    req;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_rdata;
  modport slave (input req, req_we, req_addr, req_wdata, output gnt, rsp_valid, rsp_rdata);
  modport master(output req, req_we, req_addr, req_wdata, input gnt, rsp_valid, rsp_rdata);
endinterface

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin arbiter granting up to two requesters per cycle onto RAM ports A/B.
// Optional DPRAM_ARB_COLLISION_CHECK_EN defers port B when it hits port A's address with a write.
module dpram_arbiter #(parameter int N = 4, parameter int AW = 6, parameter int DW = 8) (
  input  logic          clk,
  input  logic          rst_n,
  dpram_arbiter_if.slave bus,
  output logic          ram_we_a,
  output logic          ram_we_b,
  output logic [AW-1:0] ram_addr_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_a,
  output logic [DW-1:0] ram_data_b,
  input  logic [DW-1:0] ram_val_a,
  input  logic [DW-1:0] ram_val_b
);
  localparam int IW = $clog2(N);
  logic [IW-1:0]   ptr_q, ptr_d, a_idx, b_idx, j;
  logic [IW-1:0]   oa1_q, ob1_q, oa2_q, ob2_q;
  logic            a_ok, b_ok, b_go;
  logic [N-1:0]    elig, gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic            va1_q, vb1_q, va2_q, vb2_q, va1_d, vb1_d;
  logic            we_a_q, we_a_d, we_b_q, we_b_d;
  logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d, cand_addr_a, cand_addr_b;
  logic [DW-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
  logic [N*DW-1:0] rsp_rdata_q, rsp_rdata_d;
  always_comb begin
    elig = bus.req & ~gnt_q;
    a_ok = 1'b0;
    a_idx = '0;
    b_ok = 1'b0;
    b_idx = '0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr_q) + k) % N);
      if (!a_ok && elig[j]) begin
        a_ok = 1'b1;
        a_idx = j;
      end
    end
    for (int k = 1; k < N; k++) begin
      j = IW'((int'(a_idx) + k) % N);
      if (a_ok && !b_ok && elig[j]) begin
        b_ok = 1'b1;
        b_idx = j;
      end
    end
    cand_addr_a = bus.req_addr[a_idx*AW +: AW];
    cand_addr_b = bus.req_addr[b_idx*AW +: AW];
`ifdef DPRAM_ARB_COLLISION_CHECK_EN
    b_go = b_ok && !(cand_addr_a == cand_addr_b && (bus.req_we[a_idx] || bus.req_we[b_idx]));
`else
    b_go = b_ok;
`endif
    gnt_d = '0;
    if (a_ok) gnt_d[a_idx] = 1'b1;
    if (b_go) gnt_d[b_idx] = 1'b1;
    we_a_d   = a_ok & bus.req_we[a_idx];
    addr_a_d = a_ok ? cand_addr_a : '0;
    data_a_d = a_ok ? bus.req_wdata[a_idx*DW +: DW] : '0;
    we_b_d   = b_go & bus.req_we[b_idx];
    addr_b_d = b_go ? cand_addr_b : '0;
    data_b_d = b_go ? bus.req_wdata[b_idx*DW +: DW] : '0;
    ptr_d = b_go ? IW'((int'(b_idx) + 1) % N) : a_ok ? IW'((int'(a_idx) + 1) % N) : ptr_q;
    va1_d = a_ok & ~bus.req_we[a_idx];
    vb1_d = b_go & ~bus.req_we[b_idx];
    // Stage-2 tags line up with ram_val; response registers land one cycle later.
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (va2_q) begin
      rsp_valid_d[oa2_q] = 1'b1;
      rsp_rdata_d[oa2_q*DW +: DW] = ram_val_a;
    end
    if (vb2_q) begin
      rsp_valid_d[ob2_q] = 1'b1;
      rsp_rdata_d[ob2_q*DW +: DW] = ram_val_b;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      gnt_q <= '0;
      we_a_q <= 1'b0;
      we_b_q <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
      va1_q <= 1'b0;
      vb1_q <= 1'b0;
      va2_q <= 1'b0;
      vb2_q <= 1'b0;
      oa1_q <= '0;
      ob1_q <= '0;
      oa2_q <= '0;
      ob2_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      gnt_q <= gnt_d;
      we_a_q <= we_a_d;
      we_b_q <= we_b_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
      va1_q <= va1_d;
      vb1_q <= vb1_d;
      va2_q <= va1_q;
      vb2_q <= vb1_q;
      oa1_q <= a_idx;
      ob1_q <= b_idx;
      oa2_q <= oa1_q;
      ob2_q <= ob1_q;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign ram_we_a   = we_a_q;
  assign ram_we_b   = we_b_q;
  assign ram_addr_a = addr_a_q;
  assign ram_addr_b = addr_b_q;
  assign ram_data_a = data_a_q;
  assign ram_data_b = data_b_q;
endmodule
